// File: rtl/rr_op_sequencer.sv
// Control-step sequencer for register-register / register-unary ALU instructions:
// fetch T0-T2, decode, execute T3-T5 (+T6 for mul/div), each step STEP_CYCLES long.
module rr_op_sequencer #(
  parameter int NUM_REGS    = 16,
  parameter int STEP_CYCLES = 2,
  parameter int OPCODE_W    = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [31:0]         ir_data,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                pc_enable,
  output logic                pc_increment,
  output logic                mar_enable,
  output logic                read,
  output logic                mdr_enable,
  output logic                mdr_out,
  output logic                ir_enable,
  output logic                y_enable,
  output logic                z_enable,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                lo_enable,
  output logic                hi_enable,
  output logic [OPCODE_W-1:0] op_code,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic [2:0]          step
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [4:0] NR = 5'(NUM_REGS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, ill_q, ill_d;
  logic          last;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_md, is_un, regs_ok, bad_ir;
  logic       unused_ir;

  assign op        = ir_data[31:27];
  assign ra        = ir_data[26:23];
  assign rb        = ir_data[22:19];
  assign rc        = ir_data[18:15];
  assign unused_ir = ^ir_data[14:0];

  function automatic logic in_rng(input logic [3:0] i);
    in_rng = {1'b0, i} < NR;
  endfunction

  function automatic logic [NUM_REGS-1:0] sel(input logic [3:0] i);
    sel = NUM_REGS'(1) << i;
  endfunction

  assign is_bin  = (op >= 5'd3) && (op <= 5'd11);
  assign is_md   = (op == 5'd15) || (op == 5'd16);
  assign is_un   = (op == 5'd17) || (op == 5'd18);
  // mul/div leave ra unused, unary ops leave rc unused
  assign regs_ok = is_md ? (in_rng(rb) && in_rng(rc)) :
                   is_un ? (in_rng(ra) && in_rng(rb)) :
                           (in_rng(ra) && in_rng(rb) && in_rng(rc));
  assign bad_ir  = !(is_bin || is_md || is_un) || !regs_ok;

  assign last    = (cnt_q == CW'(STEP_CYCLES - 1));
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign illegal = ill_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = last ? '0 : cnt_q + CW'(1);
    done_d       = 1'b0;
    ill_d        = 1'b0;
    pc_out       = 1'b0;
    pc_enable    = 1'b0;
    pc_increment = 1'b0;
    mar_enable   = 1'b0;
    read         = 1'b0;
    mdr_enable   = 1'b0;
    mdr_out      = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    z_enable     = 1'b0;
    zlo_out      = 1'b0;
    zhi_out      = 1'b0;
    lo_enable    = 1'b0;
    hi_enable    = 1'b0;
    op_code      = '0;
    reg_out      = '0;
    reg_enable   = '0;
    step         = 3'd0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = T0;
      end
      T0: begin
        step         = 3'd0;
        pc_out       = 1'b1;
        mar_enable   = last;
        pc_increment = last;
        z_enable     = last;
        if (last) state_d = T1;
      end
      T1: begin
        step       = 3'd1;
        zlo_out    = 1'b1;
        read       = 1'b1;
        pc_enable  = last;
        mdr_enable = last;
        if (last) state_d = T2;
      end
      T2: begin
        step      = 3'd2;
        mdr_out   = 1'b1;
        ir_enable = last;
        if (last) state_d = T3;
      end
      T3: begin
        step = 3'd3;
        if (cnt_q == '0 && bad_ir) begin
          state_d = IDLE;
          cnt_d   = '0;
          ill_d   = 1'b1;
        end else begin
          if (!is_un) begin
            reg_out  = sel(rb);
            y_enable = last;
          end
          if (last) state_d = T4;
        end
      end
      T4: begin
        step     = 3'd4;
        op_code  = OPCODE_W'(op);
        reg_out  = is_un ? sel(rb) : sel(rc);
        z_enable = last;
        if (last) state_d = T5;
      end
      T5: begin
        step    = 3'd5;
        zlo_out = 1'b1;
        if (last) begin
          if (is_md) begin
            lo_enable = 1'b1;
            state_d   = T6;
          end else begin
            reg_enable = sel(ra);
            state_d    = IDLE;
            done_d     = 1'b1;
          end
        end
      end
      T6: begin
        step      = 3'd6;
        zhi_out   = 1'b1;
        hi_enable = last;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/rr_op_sequencer.md
# rr_op_sequencer

Parametrised control-step sequencer for the datapath. It replaces per-instruction hand-built control sequences for register-register and register-unary ALU instructions. On `start` it runs fetch (T0–T2), decodes the IR fields, and runs execute (T3–T5, plus T6 for mul/div). Each step is held for a programmable number of clock cycles. Register strobes are one-hot vectors indexed by IR fields instead of per-register wires.

## Interface
- `NUM_REGS`, 16: general registers addressed. Must be 2..16. IR register fields are 4 bits wide.
- `STEP_CYCLES`, 2: clock cycles per control step. Must be ≥1.
- `OPCODE_W`, 5: width of `op_code`.

- `clk` in 1: single clock. All state changes on its rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `start` in 1: request one instruction. Sampled only in IDLE.
- `ir_data` in 32: IR contents from the datapath. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse on normal completion.
- `illegal` out 1: one-cycle pulse on decode abort.
- `pc_out`, `pc_enable`, `pc_increment`, `mar_enable`, `read`, `mdr_enable`, `mdr_out`, `ir_enable`, `y_enable`, `z_enable`, `zlo_out`, `zhi_out`, `lo_enable`, `hi_enable` out 1 each: datapath control strobes.
- `op_code` out OPCODE_W: ALU operation select.
- `reg_out` out NUM_REGS: one-hot register bus-drive select.
- `reg_enable` out NUM_REGS: one-hot register load select.
- `step` out 3: current step number, 0 = T0 … 6 = T6. Reads 0 in IDLE.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. A step counter counts 0..STEP_CYCLES-1 inside each T state.
- Strobe classes:
  - Drive class (`*_out`, `read`, `op_code`): held for the whole step.
  - Load class (`*_enable`, `pc_increment`): asserted only in the last cycle of the step, so each register captures exactly once.
- T0: drive `pc_out`. Load `mar_enable`, `pc_increment`, `z_enable`.
- T1: drive `zlo_out`, `read`. Load `pc_enable`, `mdr_enable`.
- T2: drive `mdr_out`. Load `ir_enable`.
- From T3 onward, fields are decoded combinationally from `ir_data`. The IR is stable after T2.
- T3, first cycle, illegal-instruction check: if the opcode is not in {00011 add, 00100 sub, 00101 shr, 00110 shra, 00111 shl, 01000 ror, 01001 rol, 01010 and, 01011 or, 01111 mul, 10000 div, 10001 neg, 10010 not}, or any used register field is ≥ NUM_REGS:
  - no strobes are asserted in that cycle;
  - the next state is IDLE;
  - `illegal` pulses in the first IDLE cycle.
- T3, binary ops: drive `reg_out[rb]`. Load `y_enable`.
- T3, unary ops (neg, not): no strobes, one full step of idle.
- T4: `op_code` = IR opcode, held whole step. Drive `reg_out[rc]` (binary) or `reg_out[rb]` (unary). Load `z_enable`.
- T5, non-mul/div: drive `zlo_out`. Load `reg_enable[ra]`. Next state IDLE.
- T5, mul/div: drive `zlo_out`. Load `lo_enable`. Next state T6. ra is ignored and not range-checked.
- T6 (mul/div only): drive `zhi_out`. Load `hi_enable`. Next state IDLE.
- `done` pulses in the first IDLE cycle after T5 or T6 completes. A `start` in that same cycle is accepted.
- `start` while busy is ignored, not queued.
- `op_code` is 0 outside T4.

## Timing
- Reset (`clr` low): asynchronously forces IDLE and clears the step counter. Every output goes to 0: all strobes, `op_code`, `reg_out`, `reg_enable`, `busy`, `done`, `illegal`, `step`.
- Reset mid-instruction aborts with no `done` pulse. Release takes effect on the next rising edge.
- Sequence: `start` high at edge E, then T0 occupies cycles E+1 … E+S, where S = STEP_CYCLES.
- Latency, E to `done`:
  - 6S+1 cycles for ALU and unary ops;
  - 7S+1 cycles for mul/div;
  - 3S+2 cycles to `illegal`.
- At most one bit of `reg_out` is set, and at most one bit of `reg_enable`. Never both for the same index in the same cycle.
- The IR is loaded at the last edge of T2, so `ir_data` is sampled no earlier than the first cycle of T3.

## Test plan
- Reset: `clr` low mid-T4 → all outputs 0 immediately, state IDLE, no `done`. After release, `start` begins T0.
- ROL: `ir_data` = 0x48918000 (rol r1,r2,r3), S=2, `start` at edge 0 →
  - T3: `reg_out` = 0x0004, with `y_enable` high only in cycle 8;
  - T4: `reg_out` = 0x0008, `op_code` = 01001 for cycles 9–10;
  - T5: `reg_enable` = 0x0002 in cycle 12;
  - `done` in cycle 13;
  - `pc_increment` high for exactly 1 cycle.
- MUL: `ir_data` = 0x78118000 →
  - T5 loads `lo_enable`, T6 drives `zhi_out` and loads `hi_enable`;
  - `reg_enable` never set;
  - `done` at cycle 15.
- Unary: `ir_data` = 0x8A280000 (neg r4,r5) →
  - T3 has no strobes;
  - T4 `reg_out` = 0x0020, `op_code` = 10001;
  - T5 `reg_enable` = 0x0010.
- Illegal: `ir_data` = 0x00000000, or `NUM_REGS`=8 with ra = 9 → `illegal` pulse at cycle 3S+2, no T4 strobes, no `done`.
- Handshake: `start` held high continuously, with S=1 and S=3 → back-to-back instructions, `done` spacing of 6S+1 cycles, no `start` accepted while busy.
